// File: rtl/ppu_oam_dma.sv
// OAM DMA initiator: copies one page of CPU memory into sprite OAM through
// repeated writes to the PPU OAMDATA register while holding the CPU stalled.
module ppu_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h4004,
    parameter int          LENGTH        = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_data_in,
    input  logic        i_cpu_we,
    input  logic        i_ce,
    output logic        o_cpu_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_re,
    input  logic [7:0]  i_mem_data,
    input  logic        i_mem_valid,
    output logic [15:0] o_ppu_addr,
    output logic [7:0]  o_ppu_data,
    output logic        o_ppu_we,
    output logic        o_ppu_ce
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        READ,
        WRITE,
        DONE
    } state_t;

    // index is 9 bits so a full 256-byte page ends cleanly at 255
    localparam logic [8:0] LAST_INDEX = 9'(LENGTH - 1);

    state_t      state;
    state_t      state_nxt;
    logic [8:0]  index;
    logic [7:0]  page;
    logic [7:0]  data_lat;
    logic        trig;

    assign trig = i_ce && i_cpu_we && (i_cpu_addr == DMA_REG_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            index    <= '0;
            page     <= '0;
            data_lat <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (trig) begin
                        page  <= i_cpu_data_in;
                        index <= '0;
                    end
                end
                READ: begin
                    if (i_mem_valid) begin
                        data_lat <= i_mem_data;
                    end
                end
                WRITE: begin
                    if (index != LAST_INDEX) begin
                        index <= index + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state alone, so an async reset clears them at once
    always_comb begin
        state_nxt   = state;
        o_cpu_stall = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_addr  = 16'h0000;
        o_mem_re    = 1'b0;
        o_ppu_addr  = 16'h0000;
        o_ppu_data  = 8'h00;
        o_ppu_we    = 1'b0;
        o_ppu_ce    = 1'b0;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nxt = ALIGN;
                end
            end
            ALIGN: begin
                o_cpu_stall = 1'b1;
                o_busy      = 1'b1;
                state_nxt   = READ;
            end
            READ: begin
                o_cpu_stall = 1'b1;
                o_busy      = 1'b1;
                o_mem_re    = 1'b1;
                o_mem_addr  = {page, index[7:0]};
                if (i_mem_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                o_cpu_stall = 1'b1;
                o_busy      = 1'b1;
                o_ppu_ce    = 1'b1;
                o_ppu_we    = 1'b1;
                o_ppu_addr  = OAM_DATA_ADDR;
                o_ppu_data  = data_lat;
                state_nxt   = (index == LAST_INDEX) ? DONE : READ;
            end
            DONE: begin
                o_cpu_stall = 1'b1;
                o_busy      = 1'b1;
                o_done      = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Directed bench for ppu_oam_dma: a full-page instance and a 4-byte instance
// share the CPU bus, each with its own memory model that can insert wait states.
module tb_ppu_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic        a_ce, b_ce;
    int          wait_n;
    logic        sel;

    logic        a_stall, a_busy, a_done, a_mem_re, a_mem_valid, a_ppu_we, a_ppu_ce;
    logic [15:0] a_mem_addr, a_ppu_addr;
    logic [7:0]  a_mem_data, a_ppu_data;
    logic        b_stall, b_busy, b_done, b_mem_re, b_mem_valid, b_ppu_we, b_ppu_ce;
    logic [15:0] b_mem_addr, b_ppu_addr;
    logic [7:0]  b_mem_data, b_ppu_data;
    int          a_cnt = 0, b_cnt = 0;

    logic        m_stall, m_busy, m_done, m_mem_re, m_ppu_we, m_ppu_ce;
    logic [15:0] m_mem_addr, m_ppu_addr;
    logic [7:0]  m_ppu_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ppu_oam_dma u_dut (
        .clk(clk), .reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_data_in(cpu_data), .i_cpu_we(cpu_we), .i_ce(a_ce),
        .o_cpu_stall(a_stall), .o_busy(a_busy), .o_done(a_done),
        .o_mem_addr(a_mem_addr), .o_mem_re(a_mem_re),
        .i_mem_data(a_mem_data), .i_mem_valid(a_mem_valid),
        .o_ppu_addr(a_ppu_addr), .o_ppu_data(a_ppu_data),
        .o_ppu_we(a_ppu_we), .o_ppu_ce(a_ppu_ce)
    );

    ppu_oam_dma #(.LENGTH(4)) u_short (
        .clk(clk), .reset(reset),
        .i_cpu_addr(cpu_addr), .i_cpu_data_in(cpu_data), .i_cpu_we(cpu_we), .i_ce(b_ce),
        .o_cpu_stall(b_stall), .o_busy(b_busy), .o_done(b_done),
        .o_mem_addr(b_mem_addr), .o_mem_re(b_mem_re),
        .i_mem_data(b_mem_data), .i_mem_valid(b_mem_valid),
        .o_ppu_addr(b_ppu_addr), .o_ppu_data(b_ppu_data),
        .o_ppu_we(b_ppu_we), .o_ppu_ce(b_ppu_ce)
    );

    // Memory content is addr[7:0]^A5; valid arrives after wait_n cycles of request
    assign a_mem_data  = a_mem_addr[7:0] ^ 8'hA5;
    assign b_mem_data  = b_mem_addr[7:0] ^ 8'hA5;
    assign a_mem_valid = a_mem_re && (a_cnt >= wait_n);
    assign b_mem_valid = b_mem_re && (b_cnt >= wait_n);

    always @(posedge clk) begin
        a_cnt <= a_mem_re ? a_cnt + 1 : 0;
        b_cnt <= b_mem_re ? b_cnt + 1 : 0;
    end

    assign m_stall    = sel ? b_stall    : a_stall;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_done     = sel ? b_done     : a_done;
    assign m_mem_re   = sel ? b_mem_re   : a_mem_re;
    assign m_mem_addr = sel ? b_mem_addr : a_mem_addr;
    assign m_ppu_we   = sel ? b_ppu_we   : a_ppu_we;
    assign m_ppu_ce   = sel ? b_ppu_ce   : a_ppu_ce;
    assign m_ppu_addr = sel ? b_ppu_addr : a_ppu_addr;
    assign m_ppu_data = sel ? b_ppu_data : a_ppu_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, m_stall}, 0);
        chk({tag, "_busy"}, {31'd0, m_busy}, 0);
        chk({tag, "_done"}, {31'd0, m_done}, 0);
        chk({tag, "_mem_re"}, {31'd0, m_mem_re}, 0);
        chk({tag, "_mem_addr"}, {16'd0, m_mem_addr}, 0);
        chk({tag, "_ppu_strobe"}, {30'd0, m_ppu_we, m_ppu_ce}, 0);
        chk({tag, "_ppu_addr"}, {16'd0, m_ppu_addr}, 0);
        chk({tag, "_ppu_data"}, {24'd0, m_ppu_data}, 0);
    endtask

    // Called from a negedge; triggers page pg and follows the transfer cycle by cycle
    // until the first idle cycle, or aborts with reset after abort_at writes.
    task automatic xfer(input logic [7:0] pg, input int len, input int exp_stall,
                        input int abort_at, input bit retrig);
        int          stall_cnt = 0;
        int          writes    = 0;
        int          dones     = 0;
        logic        prev_re   = 1'b0;
        logic [15:0] prev_addr = 16'h0000;
        bit          rt_sent   = 1'b0;
        cpu_addr = 16'h4014;
        cpu_data = pg;
        cpu_we   = 1'b1;
        a_ce     = !sel;
        b_ce     = sel;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            cpu_we = 1'b0;
            a_ce   = 1'b0;
            b_ce   = 1'b0;
            if (m_stall) stall_cnt++;
            else if (stall_cnt > 0) break;
            chk("busy_eq_stall", {31'd0, m_busy}, {31'd0, m_stall});
            chk("strobe_excl", {31'd0, m_mem_re && (m_ppu_ce || m_ppu_we)}, 0);
            if (m_mem_re) begin
                chk("mem_addr", {16'd0, m_mem_addr}, {16'd0, pg, 8'(writes)});
                if (prev_re) chk("mem_addr_stable", {16'd0, m_mem_addr}, {16'd0, prev_addr});
            end else begin
                chk("mem_addr_idle", {16'd0, m_mem_addr}, 0);
            end
            if (m_ppu_we || m_ppu_ce) begin
                chk("ppu_strobe", {30'd0, m_ppu_we, m_ppu_ce}, 3);
                chk("ppu_addr", {16'd0, m_ppu_addr}, 32'h4004);
                chk("ppu_data", {24'd0, m_ppu_data}, {24'd0, 8'(writes) ^ 8'hA5});
                writes++;
            end else begin
                chk("ppu_quiet", {8'd0, m_ppu_addr, m_ppu_data}, 0);
            end
            if (m_done) dones++;
            prev_re   = m_mem_re;
            prev_addr = m_mem_addr;
            if (retrig && writes == 10 && !rt_sent && m_mem_re) begin
                rt_sent  = 1'b1;
                cpu_data = 8'h03;
                cpu_we   = 1'b1;
                a_ce     = !sel;
                b_ce     = sel;
            end
            if (retrig && m_done) begin
                cpu_data = 8'h03;
                cpu_we   = 1'b1;
                a_ce     = !sel;
                b_ce     = sel;
            end
            if (abort_at >= 0 && writes == abort_at) begin
                reset = 1'b0;
                #1;
                chk_all_zero("abort");
                @(negedge clk);
                chk_all_zero("abort_hold");
                reset = 1'b1;
                return;
            end
        end
        chk("stall_width", stall_cnt, exp_stall);
        chk("write_count", writes, len);
        chk("done_pulses", dones, 1);
    endtask

    initial begin
        reset    = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        cpu_we   = 1'b0;
        a_ce     = 1'b0;
        b_ce     = 1'b0;
        wait_n   = 0;
        sel      = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_a");
        sel = 1'b1;
        chk_all_zero("reset_b");
        sel   = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Basic page copy, zero-wait memory
        xfer(8'h02, 256, 514, -1, 1'b0);

        // Three wait cycles on every read
        wait_n = 3;
        xfer(8'h02, 256, 1282, -1, 1'b0);
        wait_n = 0;

        // Triggers at byte 10 and during DONE are ignored; one in the first idle cycle starts page 3
        xfer(8'h02, 256, 514, -1, 1'b1);
        xfer(8'h03, 256, 514, -1, 1'b0);

        // Reset at byte 100, then a fresh page-5 transfer from index 0
        xfer(8'h02, 256, 514, 100, 1'b0);
        @(negedge clk);
        xfer(8'h05, 256, 514, -1, 1'b0);

        // CPU read of the DMA register does not trigger
        cpu_addr = 16'h4014;
        cpu_data = 8'h07;
        cpu_we   = 1'b0;
        a_ce     = 1'b1;
        @(negedge clk);
        a_ce = 1'b0;
        chk("read_no_stall", {31'd0, a_stall}, 0);
        @(negedge clk);
        chk("read_no_busy", {30'd0, a_stall, a_busy}, 0);

        // Write without chip enable does not trigger
        cpu_we = 1'b1;
        a_ce   = 1'b0;
        @(negedge clk);
        cpu_we = 1'b0;
        chk("noce_no_stall", {31'd0, a_stall}, 0);
        @(negedge clk);
        chk("noce_no_busy", {30'd0, a_stall, a_busy}, 0);

        // Four-byte instance from page $10
        sel = 1'b1;
        xfer(8'h10, 4, 10, -1, 1'b0);
        sel = 1'b0;
        chk("full_idle_during_short", {31'd0, a_stall}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu_oam_dma.md
Name: ppu_oam_dma

Overview:
- Bus initiator that copies one 256-byte page of CPU memory into sprite OAM by issuing MMIO writes to the OAMDATA register in the PPU register window.
- Triggered by a CPU write of a page number to the DMA register.
- Stalls the CPU for the whole transfer.
- Sits beside the BusControlUnit: its CPU-side decode receives the trigger, its memory port reads system RAM, and its PPU-side port drives the PPU register block's CPU MMIO interface while the CPU is halted.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address of the DMA trigger register.
- OAM_DATA_ADDR, 16'h4004, PPU register address written for each byte (OAMDATA).
- LENGTH, 256, bytes per transfer; legal range 1..256.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- i_cpu_addr  input  16  CPU address bus.
- i_cpu_data_in  input  8  CPU write data; the page number on trigger.
- i_cpu_we  input  1  CPU write enable.
- i_ce  input  1  chip enable from BusControlUnit for DMA_REG_ADDR.
- o_cpu_stall  output  1  halts the CPU while a transfer is active.
- o_busy  output  1  transfer in progress (IDLE excluded).
- o_done  output  1  one-cycle pulse at transfer completion.
- o_mem_addr  output  16  source read address.
- o_mem_re  output  1  source read request.
- i_mem_data  input  8  source read data.
- i_mem_valid  input  1  read data valid; may arrive in the first or any later cycle of a request.
- o_ppu_addr  output  16  address to the PPU register block.
- o_ppu_data  output  8  write data to the PPU register block.
- o_ppu_we  output  1  write enable to the PPU register block.
- o_ppu_ce  output  1  chip enable to the PPU register block.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; index=0; page=0; data latch=0.
  - All outputs are 0, including o_ppu_addr and o_mem_addr.
- Trigger:
  - Condition: i_ce=1, i_cpu_we=1 and i_cpu_addr==DMA_REG_ADDR, sampled at rising edge T while in IDLE.
  - Action: page <= i_cpu_data_in, index <= 0, state <= ALIGN.
  - Triggers seen in any non-IDLE state are ignored; page and index are unchanged.
- States:
  - IDLE: stall=0, busy=0.
  - ALIGN: a single dead cycle; stall=1, busy=1; next state is READ.
  - READ:
    - o_mem_re=1, o_mem_addr={page, index[7:0]}.
    - If i_mem_valid=1 at the edge: latch i_mem_data and go to WRITE.
    - Otherwise stay in READ with the address held stable.
  - WRITE:
    - o_ppu_ce=1, o_ppu_we=1, o_ppu_addr=OAM_DATA_ADDR, o_ppu_data=latched byte, held for exactly one cycle.
    - If index==LENGTH-1: go to DONE.
    - Else: index <= index+1 and go to READ.
  - DONE: o_done=1 for one cycle; stall=1, busy=1; next state is IDLE.
- Strobe exclusivity:
  - o_mem_re and the o_ppu_ce/o_ppu_we pair are never high in the same cycle.
  - o_ppu_* is 0 outside WRITE; o_mem_* is 0 outside READ.
- Timing:
  - o_cpu_stall rises in the cycle after edge T and falls in the cycle after DONE.
  - With i_mem_valid high in the first READ cycle, each byte takes 2 cycles. Stall width = 1 + 2*LENGTH + 1 cycles, i.e. 514 for LENGTH=256.
  - Each wait cycle on i_mem_valid adds exactly one stall cycle.
- Arithmetic:
  - index is 9 bits wide, so LENGTH=256 terminates at index 255.
  - The low address byte never carries into page; source addresses stay within the page.
- Reset mid-transfer:
  - The transfer aborts immediately. Stall, strobes and busy drop asynchronously.
  - No o_done pulse is issued, and the next trigger starts again from index 0.
- Trigger in DONE: ignored. Trigger in the first IDLE cycle after DONE: accepted.

Test Plan:
- Basic copy: memory $0200–$02FF holds byte=addr[7:0]^8'hA5; write $02 to $4014 with zero-wait valid -> 256 writes to $4004 carrying $A5,$A4,…,$5A in order; o_cpu_stall high for exactly 514 cycles; one o_done pulse.
- Wait states: same setup, but i_mem_valid is delayed 3 cycles on every read -> 256 writes in the same order; stall width 514+3*256=1282; o_mem_addr stable throughout each wait.
- Retrigger while busy: write $03 to $4014 at byte 10 of a page-$02 transfer -> ignored; all 256 source addresses are $02xx; a trigger one cycle after DONE starts a page-$03 transfer.
- Reset mid-transfer: assert reset at byte 100 -> outputs 0 in the same cycle, no o_done; after release, a new page-$05 trigger reads from $0500 with index restarting at 0.
- Non-trigger accesses:
  - Read of $4014 (i_cpu_we=0) -> no transfer.
  - Write with i_ce=0 -> no transfer.
  - Both cases: stall stays 0.
- Short length: LENGTH=4, page $10 -> exactly 4 writes from $1000–$1003; stall width 10 cycles; strobe exclusivity holds every cycle.
